// File: rtl/edge_pkg.sv
// Shared widths, the Sobel Gx reset kernel and the serializer state encoding
// for the edge-detection pipeline front end.
package edge_pkg;

    localparam int unsigned FP_W = 32;
    localparam int unsigned TAPS = 9;

    // Packed with tap 0 in the least significant slot, so SOBEL_GX[k] is tap k.
    localparam logic [TAPS-1:0][FP_W-1:0] SOBEL_GX = {
        32'h3F800000, 32'h00000000, 32'hBF800000,
        32'h40000000, 32'h00000000, 32'hC0000000,
        32'h3F800000, 32'h00000000, 32'hBF800000
    };

    typedef enum logic {
        FILL,
        EMIT
    } state_e;

endpackage

// File: rtl/window_serializer_line_buffer.sv
// Single-port line memory: asynchronous read and synchronous write at one
// address, so a read-before-write swap happens in a single accepted cycle.
module line_buffer #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/window_serializer.sv
// Buffers two raster lines, forms a 3x3 window per interior pixel and
// serializes it as 9 (pixel, coefficient) beats toward the mac stage.
module window_serializer
    import edge_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] in_pixel_fp,
    input  logic            in_pixel_valid,
    output logic            ou_pixel_ready,
    input  logic            in_coeff_wr,
    input  logic [3:0]      in_coeff_addr,
    input  logic [FP_W-1:0] in_coeff_data,
    output logic [FP_W-1:0] ou_grayscale_fp,
    output logic [FP_W-1:0] ou_kernel_coeff,
    output logic            ou_data_valid,
    input  logic            in_data_ready,
    output logic            ou_data_last,
    output logic            ou_last_pixel
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [3:0]    TAP_LAST = 4'(TAPS - 1);

    state_e                      state_q;
    logic [CW-1:0]               col_q;
    logic [RW-1:0]               row_q;
    logic [3:0]                  tap_q;
    logic [3:0]                  tap_nxt;
    logic                        ready_q;
    logic                        valid_q;
    logic                        last_q;
    logic                        lastpix_q;
    logic [FP_W-1:0]             pix_q;
    logic [FP_W-1:0]             coeff_q;
    logic [TAPS-1:0][FP_W-1:0]   staging_q;
    logic [TAPS-1:0][FP_W-1:0]   active_q;
    logic [FP_W-1:0]             win_q [TAPS];
    logic [FP_W-1:0]             win_d [TAPS];
    logic [FP_W-1:0]             lb1_rd;
    logic [FP_W-1:0]             lb2_rd;
    logic                        accept;
    logic                        trigger;
    logic                        beat_hs;

    assign accept  = in_pixel_valid && ready_q;
    assign trigger = accept && (col_q >= CW'(2)) && (row_q >= RW'(2));
    assign beat_hs = valid_q && in_data_ready;
    assign tap_nxt = tap_q + 4'd1;

    assign ou_pixel_ready  = ready_q;
    assign ou_data_valid   = valid_q;
    assign ou_data_last    = last_q;
    assign ou_last_pixel   = lastpix_q;
    assign ou_grayscale_fp = pix_q;
    assign ou_kernel_coeff = coeff_q;

    // lb1 holds row r-1; its old contents cascade into lb2 (row r-2).
    line_buffer #(.DEPTH(IMG_W), .WIDTH(FP_W), .AW(CW)) u_lb1 (
        .clk_i   (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (in_pixel_fp),
        .rdata_o (lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(FP_W), .AW(CW)) u_lb2 (
        .clk_i   (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i (lb1_rd),
        .rdata_o (lb2_rd)
    );

    // Window stored row-major so tap k is simply win_q[k].
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int unsigned i = 0; i < 3; i++) begin
                win_d[3*i]     = win_q[3*i + 1];
                win_d[3*i + 1] = win_q[3*i + 2];
            end
            win_d[2] = lb2_rd;
            win_d[5] = lb1_rd;
            win_d[8] = in_pixel_fp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            win_q <= win_d;
            if (accept) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FILL;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            lastpix_q <= 1'b0;
            pix_q     <= '0;
            coeff_q   <= '0;
            tap_q     <= '0;
            staging_q <= SOBEL_GX;
            active_q  <= SOBEL_GX;
        end else begin
            if (in_coeff_wr && (in_coeff_addr < 4'(TAPS))) begin
                staging_q[in_coeff_addr] <= in_coeff_data;
            end
            case (state_q)
                FILL: begin
                    active_q <= staging_q;
                    if (trigger) begin
                        // Tap 0 comes from the post-shift window and the bank being copied now.
                        state_q   <= EMIT;
                        ready_q   <= 1'b0;
                        valid_q   <= 1'b1;
                        last_q    <= 1'b0;
                        tap_q     <= '0;
                        pix_q     <= win_d[0];
                        coeff_q   <= staging_q[0];
                        lastpix_q <= (row_q == ROW_LAST) && (col_q == COL_LAST);
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                EMIT: begin
                    if (beat_hs) begin
                        if (tap_q == TAP_LAST) begin
                            state_q   <= FILL;
                            ready_q   <= 1'b1;
                            valid_q   <= 1'b0;
                            last_q    <= 1'b0;
                            lastpix_q <= 1'b0;
                        end else begin
                            tap_q   <= tap_nxt;
                            pix_q   <= win_q[tap_nxt];
                            coeff_q <= active_q[tap_nxt];
                            last_q  <= (tap_nxt == TAP_LAST);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_serializer.sv
// Randomized self-checking bench for window_serializer on a 4x4 frame, with
// a window-level reference model built from the frame's pixel array.
module tb_window_serializer;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_pixel_fp;
    logic        in_pixel_valid;
    logic        ou_pixel_ready;
    logic        in_coeff_wr;
    logic [3:0]  in_coeff_addr;
    logic [31:0] in_coeff_data;
    logic [31:0] ou_grayscale_fp;
    logic [31:0] ou_kernel_coeff;
    logic        ou_data_valid;
    logic        in_data_ready;
    logic        ou_data_last;
    logic        ou_last_pixel;

    window_serializer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_pixel_fp     (in_pixel_fp),
        .in_pixel_valid  (in_pixel_valid),
        .ou_pixel_ready  (ou_pixel_ready),
        .in_coeff_wr     (in_coeff_wr),
        .in_coeff_addr   (in_coeff_addr),
        .in_coeff_data   (in_coeff_data),
        .ou_grayscale_fp (ou_grayscale_fp),
        .ou_kernel_coeff (ou_kernel_coeff),
        .ou_data_valid   (ou_data_valid),
        .in_data_ready   (in_data_ready),
        .ou_data_last    (ou_data_last),
        .ou_last_pixel   (ou_last_pixel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pix;
        logic [31:0] coeff;
        logic        last;
        logic        lastpix;
    } beat_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    logic [31:0] sobel [9] = '{32'hBF800000, 32'h00000000, 32'h3F800000,
                               32'hC0000000, 32'h00000000, 32'h40000000,
                               32'hBF800000, 32'h00000000, 32'h3F800000};
    logic [31:0] mcoef [9];
    logic [31:0] pix_arr [$];
    beat_t       exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] itof(input int unsigned k);
        int unsigned e = 0;
        logic [31:0] m;
        if (k == 0) return 32'h0;
        for (int unsigned i = 0; i < 24; i++) if ((k >> i) != 0) e = i;
        m = (k - (32'd1 << e)) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic bit interior(input int idx);
        int p = idx % (W * H);
        return (p / W >= 2) && (p % W >= 2);
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        in_pixel_valid = 1'b0; in_pixel_fp = '0; in_data_ready = 1'b0;
        in_coeff_wr = 1'b0; in_coeff_addr = '0; in_coeff_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", ou_pixel_ready, 1'b0);
        check("rst_valid", ou_data_valid, 1'b0);
        check("rst_last", ou_data_last, 1'b0);
        check("rst_lastpix", ou_last_pixel, 1'b0);
        check("rst_pix", ou_grayscale_fp, 32'h0);
        check("rst_coeff", ou_kernel_coeff, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", ou_pixel_ready, 1'b1);
        for (int k = 0; k < 9; k++) mcoef[k] = sobel[k];
    endtask

    task automatic write_coeff(input logic [3:0] a, input logic [31:0] d);
        in_pixel_valid = 1'b0;
        in_coeff_wr = 1'b1; in_coeff_addr = a; in_coeff_data = d;
        @(negedge clk);
        in_coeff_wr = 1'b0;
    endtask

    // Streams nframes frames back to back; abort_at > 0 stops after that many beats.
    task automatic run_stream(input int nframes, input bit rnd, input bit bp,
                              input bit wr4, input int abort_at);
        int pi = 0, bi = 0, cyc = 0, w = 0, total, npix;
        bit expect_tap0 = 0, stall_prev = 0, wr_done = 0, stop = 0;
        beat_t held, b, e;
        pix_arr.delete();
        exp_q.delete();
        for (int f = 0; f < nframes; f++)
            for (int i = 0; i < W * H; i++)
                pix_arr.push_back(rnd ? 32'($urandom) : itof(i));
        for (int f = 0; f < nframes; f++)
            for (int r = 2; r < H; r++)
                for (int c = 2; c < W; c++) begin
                    for (int k = 0; k < 9; k++) begin
                        b.pix     = pix_arr[f*W*H + (r - 2 + k/3)*W + (c - 2 + k%3)];
                        b.coeff   = (wr4 && w >= 1 && k == 4) ? 32'h3F800000 : mcoef[k];
                        b.last    = (k == 8);
                        b.lastpix = (r == H - 1) && (c == W - 1);
                        exp_q.push_back(b);
                    end
                    w++;
                end
        total = exp_q.size();
        npix  = pix_arr.size();
        while (!stop) begin
            @(negedge clk);
            cyc++;
            if (expect_tap0) check("tap0_latency", ou_data_valid, 1'b1);
            expect_tap0 = 0;
            check("ready_iff_fill", ou_pixel_ready, !ou_data_valid);
            if (stall_prev) begin
                check("stall_valid", ou_data_valid, 1'b1);
                check("stall_pix", ou_grayscale_fp, held.pix);
                check("stall_coeff", ou_kernel_coeff, held.coeff);
                check("stall_last", ou_data_last, held.last);
                check("stall_lastpix", ou_last_pixel, held.lastpix);
            end
            if ((abort_at > 0 && bi == abort_at) || bi == total || cyc > 400 * nframes) begin
                stop = 1;
            end else begin
                in_coeff_wr = 1'b0;
                if (wr4 && !wr_done && bi == 2) begin
                    in_coeff_wr = 1'b1; in_coeff_addr = 4'd4; in_coeff_data = 32'h3F800000;
                    wr_done = 1;
                end
                in_data_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                in_pixel_valid = (pi < npix);
                in_pixel_fp    = (pi < npix) ? pix_arr[pi] : 32'($urandom);
                if (in_pixel_valid && ou_pixel_ready) begin
                    if (interior(pi)) expect_tap0 = 1;
                    pi++;
                end
                if (ou_data_valid && in_data_ready) begin
                    e = exp_q.pop_front();
                    check($sformatf("beat%0d_pix", bi), ou_grayscale_fp, e.pix);
                    check($sformatf("beat%0d_coeff", bi), ou_kernel_coeff, e.coeff);
                    check($sformatf("beat%0d_last", bi), ou_data_last, e.last);
                    check($sformatf("beat%0d_lastpix", bi), ou_last_pixel, e.lastpix);
                    bi++;
                end
                stall_prev   = ou_data_valid && !in_data_ready;
                held.pix     = ou_grayscale_fp;
                held.coeff   = ou_kernel_coeff;
                held.last    = ou_data_last;
                held.lastpix = ou_last_pixel;
            end
        end
        in_coeff_wr = 1'b0;
        if (abort_at == 0) begin
            check("beat_count", bi, total);
            in_pixel_valid = 1'b0;
            in_data_ready  = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check("no_extra_beat", ou_data_valid, 1'b0);
            end
            if (wr4) mcoef[4] = 32'h3F800000;
        end
    endtask

    initial begin
        do_reset();
        write_coeff(4'd12, 32'h12345678);
        run_stream(1, 1'b0, 1'b0, 1'b0, 0);
        run_stream(1, 1'b0, 1'b1, 1'b0, 0);
        run_stream(1, 1'b0, 1'b0, 1'b1, 0);
        run_stream(2, 1'b1, 1'b1, 1'b0, 0);
        run_stream(1, 1'b0, 1'b0, 1'b0, 4);
        rst = 1'b0;
        #1;
        check("async_rst_valid", ou_data_valid, 1'b0);
        check("async_rst_pix", ou_grayscale_fp, 32'h0);
        check("async_rst_coeff", ou_kernel_coeff, 32'h0);
        check("async_rst_ready", ou_pixel_ready, 1'b0);
        do_reset();
        run_stream(1, 1'b0, 1'b0, 1'b0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/window_serializer.md
# window_serializer

Upstream feeder for the `mac` stage of the fp edge-detection pipeline. Accepts a raster-order stream of fp32 grayscale pixels and buffers two lines. It forms a 3x3 window for every interior pixel position and serializes each window as 9 (pixel, coefficient) beats on an AXI-stream-style handshake. Per-window `ou_data_last` and per-frame `ou_last_pixel` marks are generated here and travel through the multiplier and accumulator unchanged.

## Interface
- `IMG_W`, 640, frame width in pixels (>= 3)
- `IMG_H`, 480, frame height in lines (>= 3)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_pixel_fp`  in  32  grayscale pixel, IEEE-754 single
- `in_pixel_valid`  in  1  pixel present
- `ou_pixel_ready`  out  1  pixel accepted when valid&ready
- `in_coeff_wr`  in  1  coefficient write strobe
- `in_coeff_addr`  in  4  tap index 0..8 (row-major, 0 = top-left); 9..15 ignored
- `in_coeff_data`  in  32  fp32 coefficient
- `ou_grayscale_fp`  out  32  window tap pixel → `mac.in_grayscale_fp`
- `ou_kernel_coeff`  out  32  matching coefficient → `mac.in_kernel_coeff`
- `ou_data_valid`  out  1  beat valid
- `in_data_ready`  in  1  downstream ready (`mac.ou_data_ready`)
- `ou_data_last`  out  1  high on tap 8 of every window
- `ou_last_pixel`  out  1  high on all 9 beats of the frame's final window

## Operation
- States: FILL (accept pixels) and EMIT (serialize a window). Reset state is FILL.
- Counters: `col` 0..IMG_W-1 and `row` 0..IMG_H-1 advance on each accepted pixel. `col` wraps to 0 and increments `row`. After (IMG_H-1, IMG_W-1), both return to 0.
- Line buffers: two IMG_W×32 memories hold rows r-1 and r-2. They are read and written at `col` on acceptance.
- Window: a 3×3 register array shifts left one column per accepted pixel. The new right column is {lb r-2, lb r-1, incoming pixel}.
- Transition FILL→EMIT occurs when the accepted pixel has `col>=2 && row>=2`. Otherwise the block stays in FILL.
- EMIT issues taps 0..8 in row-major order:
  - Tap k pixel = window[k/3][k%3], coefficient = active[k].
  - Tap 8 accepted → FILL.
- Coefficients:
  - Writes always go to a staging bank.
  - The active bank copies the staging bank every cycle in FILL and is frozen in EMIT.
  - A write during EMIT is therefore applied to the next window.
  - Reset values (Sobel Gx) for taps 0..8: BF800000, 00000000, 3F800000, C0000000, 00000000, 40000000, BF800000, 00000000, 3F800000.
- `ou_last_pixel` is high when the window belongs to pixel (IMG_H-1, IMG_W-1).
- Outputs per frame: (IMG_W-2)(IMG_H-2) windows, 9 beats each.
- Border pixels are consumed and produce no output.
- No arithmetic is performed on pixel data. Pixels are passed through bit-exact.

## Timing
- Reset values of all outputs:
  - `ou_pixel_ready` = 0.
  - `ou_data_valid`, `ou_data_last`, `ou_last_pixel` = 0.
  - Data outputs = 0.
- `ou_pixel_ready` is registered. It is 1 from the first edge after reset release and 1 exactly when in FILL.
- Latency: tap 0 is valid on the cycle after the handshake of the triggering pixel.
- `ou_pixel_ready` drops in that same cycle. It returns to 1 the cycle after tap 8 handshakes.
- Throughput: 1 beat/cycle with `in_data_ready` held high. The minimum interior pixel period is 10 cycles.
- Backpressure: while `ou_data_valid && !in_data_ready`, all beat outputs hold stable. `ou_data_valid` never deasserts before the handshake.
- `ou_pixel_ready` is 0 throughout EMIT. Input pixels stall, with none dropped.
- Reset asserted mid-EMIT: the window is discarded, counters clear, line buffer contents are don't-care, and the staging and active banks return to Sobel Gx.
- Line buffers are single-port RAMs, inferred, with 1 read + 1 write per accepted pixel. The read completes the same cycle (distributed) or is pipelined invisibly inside FILL.

## Structure
- Package `edge_pkg`:
  - `FP_W = 32`, `TAPS = 9`.
  - The Sobel Gx reset constant array.
  - The state enum {FILL, EMIT}.
- Sub-module `line_buffer` (parameters depth IMG_W, width 32), instantiated twice.
- The top holds the counters, window registers, coefficient banks and FSM.

## Test plan
- Reset, then a 4×4 frame (IMG_W=IMG_H=4) with pixel k = float(k), ready tied high:
  - Exactly 4 windows.
  - First window pixels 0,1,2,4,5,6,8,9,10.
  - `ou_data_last` on beats 9,18,27,36.
  - `ou_last_pixel` only on beats 28..36.
  - Coefficients match Sobel Gx.
- Same frame with `in_data_ready` toggling 1-0-0-1 pseudo-randomly: beat sequence identical, with outputs stable during every stall cycle.
- Write addr 4 = 3F800000 during the first window's EMIT: first window tap 4 coeff = 00000000, second window tap 4 coeff = 3F800000.
- Two back-to-back 4×4 frames: second frame windows start at pixel 10 of frame 2, with no data carried across the frame boundary.
- Assert `rst` low mid-EMIT (after beat 4): outputs go to 0 asynchronously. After release, a fresh frame reproduces the first-scenario sequence exactly.
- Write to addr 12: no change to any coefficient.
